// File: rtl/ecp3_pcie_pkg.sv
// Shared constants and types for the master-FIFO to ECP3 PCIe TX path.
package ecp3_pcie_pkg;

  localparam int unsigned REC_W       = 18;
  localparam int unsigned REC_SOP_BIT = 17;
  localparam int unsigned REC_EOP_BIT = 16;

  localparam logic [3:0] DEF_CMD_MWR = 4'h9;

  localparam logic [2:0] TLP_FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;

  localparam int unsigned CRED_UNIT_BYTES = 16;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD,
    CRED,
    SEND
  } state_t;

  // Posted data credits needed for one payload of dw doublewords.
  function automatic int unsigned pd_units(input int unsigned dw);
    return (dw * 4 + CRED_UNIT_BYTES - 1) / CRED_UNIT_BYTES;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + 9'(inc);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/mst_tlp_sender_if.sv
// ECP3 PCIe core 16-bit TX port: request/ready handshake, data and posted credits.
interface mst_tlp_sender_if;
  logic        tx_req;
  logic        tx_rdy;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;
  logic [8:0]  tx_ca_ph;
  logic [12:0] tx_ca_pd;

  modport master (
    output tx_req, tx_st, tx_end, tx_data,
    input  tx_rdy, tx_ca_ph, tx_ca_pd
  );

  modport slave (
    input  tx_req, tx_st, tx_end, tx_data,
    output tx_rdy, tx_ca_ph, tx_ca_pd
  );
endinterface

// File: rtl/tlp_stage_buf.sv
// Whole-record stage buffer: register file with write/read pointers and clear.
module tlp_stage_buf #(
  parameter  int unsigned DEPTH = 32,
  parameter  int unsigned WIDTH = 18,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_adv,
  output logic [15:0]      rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] w_wr_base;
  logic [PTR_W-1:0] w_rd_base;

  // Clear and write may coincide: the write then lands in slot 0.
  assign w_wr_base = clr ? '0 : r_wr_ptr;
  assign w_rd_base = clr ? '0 : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en && (32'(w_wr_base) < DEPTH)) begin
      r_mem[w_wr_base[PTR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wr_base + CNT_W'(wr_en);
      r_rd_ptr <= w_rd_base + PTR_W'(rd_adv);
    end
  end

  assign rd_data = r_mem[r_rd_ptr][15:0];
  assign count   = r_wr_ptr;

endmodule

// File: rtl/mst_tlp_sender.sv
// Stages one master-FIFO record, then emits it as a 3DW MWr TLP on the ECP3 TX port.
module mst_tlp_sender
  import ecp3_pcie_pkg::*;
#(
  parameter int unsigned PAYLOAD_DW = 8,
  parameter int unsigned BUF_DEPTH  = 32,
  parameter logic [3:0]  CMD_MWR    = DEF_CMD_MWR
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     enable,
  input  logic [17:0]              mst_dout,
  input  logic                     mst_empty,
  output logic                     mst_rd_en,
  input  logic [15:0]              requester_id,
  mst_tlp_sender_if.master         tx,
  output logic [15:0]              tlp_sent_cnt,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned REC_WORDS = 3 + 2 * PAYLOAD_DW;
  localparam int unsigned TLP_WORDS = 6 + 2 * PAYLOAD_DW;
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IDX_W     = $clog2(TLP_WORDS);
  localparam int unsigned PD_NEED   = pd_units(PAYLOAD_DW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLP_WORDS - 1);

  localparam logic [15:0] HDR0 = {TLP_FMT_3DW_DATA, TLP_TYPE_MEM, 1'b0, 3'b000, 4'b0000};
  localparam logic [15:0] HDR1 = {1'b0, 1'b0, 2'b00, 2'b00, 10'(PAYLOAD_DW)};

  state_t           r_state;
  logic             r_rd_pend;
  logic [7:0]       r_be;
  logic [7:0]       r_tag;
  logic [15:0]      r_sent;
  logic [7:0]       r_drop;
  logic             r_tx_req;
  logic             r_tx_st;
  logic             r_tx_end;
  logic [15:0]      r_tx_data;
  logic [IDX_W-1:0] r_idx;

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [15:0]      w_rd_data;
  logic             w_rd_en;
  logic             w_sop;
  logic             w_eop;
  logic             w_cmd_ok;
  logic             w_cred_ok;
  logic             w_wr;
  logic             w_clr;
  logic [1:0]       w_drop_inc;
  logic             w_go_load;
  logic             w_go_idle;
  logic             w_go_cred;
  logic [IDX_W-1:0] w_load_idx;
  logic [15:0]      w_next_word;
  logic             w_rd_adv;
  logic             w_last_acc;

  assign w_sop      = mst_dout[REC_SOP_BIT];
  assign w_eop      = mst_dout[REC_EOP_BIT];
  assign w_cmd_ok   = (mst_dout[15:12] == CMD_MWR);
  assign w_cnt_next = w_cnt + CNT_W'(1);
  assign w_last_acc = (r_state == SEND) && tx.tx_rdy && (r_idx == LAST_IDX);

  assign w_cred_ok = (tx.tx_ca_ph[8] || (tx.tx_ca_ph[7:0] != 8'd0)) &&
                     (tx.tx_ca_pd[12] || (tx.tx_ca_pd[11:0] >= 12'(PD_NEED)));

  // Reads stop once the record's word count is covered, so no word of the
  // next record is ever in flight when the buffer hands over to CRED.
  always_comb begin
    w_rd_en = 1'b0;
    case (r_state)
      LOAD_IDLE: w_rd_en = !mst_empty && enable;
      LOAD:      w_rd_en = !mst_empty &&
                           ((32'(w_cnt) + 32'(r_rd_pend)) < REC_WORDS) &&
                           ((32'(w_cnt) + 32'(r_rd_pend)) < BUF_DEPTH);
      default:   w_rd_en = 1'b0;
    endcase
  end

  assign mst_rd_en = w_rd_en;

  always_comb begin
    w_wr       = 1'b0;
    w_clr      = 1'b0;
    w_drop_inc = 2'd0;
    w_go_load  = 1'b0;
    w_go_idle  = 1'b0;
    w_go_cred  = 1'b0;
    if (r_rd_pend) begin
      case (r_state)
        LOAD_IDLE: begin
          if (w_sop) begin
            if (w_cmd_ok) begin
              w_wr      = 1'b1;
              w_go_load = 1'b1;
            end else begin
              w_drop_inc = 2'd1;
            end
          end
        end
        LOAD: begin
          if (w_sop) begin
            // Mid-record SOP: drop the partial record, restart on this word.
            w_clr = 1'b1;
            if (w_cmd_ok) begin
              w_drop_inc = 2'd1;
              w_wr       = 1'b1;
              w_go_load  = 1'b1;
            end else begin
              w_drop_inc = 2'd2;
              w_go_idle  = 1'b1;
            end
          end else if (w_cnt_next == CNT_W'(REC_WORDS)) begin
            if (w_eop) begin
              w_wr      = 1'b1;
              w_go_cred = 1'b1;
            end else begin
              w_clr      = 1'b1;
              w_drop_inc = 2'd1;
              w_go_idle  = 1'b1;
            end
          end else if (w_eop) begin
            w_clr      = 1'b1;
            w_drop_inc = 2'd1;
            w_go_idle  = 1'b1;
          end else begin
            w_wr = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (w_last_acc) begin
      w_clr = 1'b1;
    end
  end

  // Buffer slot 0 holds w0 (kept in r_be), so the read pointer skips it on
  // the way into SEND and then tracks header words 4.. onward.
  assign w_load_idx = (r_state == SEND) ? (r_idx + IDX_W'(1)) : '0;
  assign w_rd_adv   = ((r_state == CRED) && w_cred_ok) ||
                      ((r_state == SEND) && tx.tx_rdy && (r_idx != LAST_IDX) &&
                       (w_load_idx >= IDX_W'(4)));

  always_comb begin
    w_next_word = w_rd_data;
    case (w_load_idx)
      IDX_W'(0): w_next_word = HDR0;
      IDX_W'(1): w_next_word = HDR1;
      IDX_W'(2): w_next_word = requester_id;
      IDX_W'(3): w_next_word = {r_tag, r_be};
      IDX_W'(5): w_next_word = {w_rd_data[15:2], 2'b00};
      default:   w_next_word = w_rd_data;
    endcase
  end

  tlp_stage_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (REC_W)
  ) u_buf (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .clr     (w_clr),
    .wr_en   (w_wr),
    .wr_data (mst_dout),
    .rd_adv  (w_rd_adv),
    .rd_data (w_rd_data),
    .count   (w_cnt)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= LOAD_IDLE;
      r_rd_pend <= 1'b0;
      r_be      <= '0;
      r_tag     <= '0;
      r_sent    <= '0;
      r_drop    <= '0;
      r_tx_req  <= 1'b0;
      r_tx_st   <= 1'b0;
      r_tx_end  <= 1'b0;
      r_tx_data <= '0;
      r_idx     <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      r_drop    <= sat_add8(r_drop, w_drop_inc);
      case (r_state)
        LOAD_IDLE, LOAD: begin
          if (w_go_load) begin
            r_be    <= mst_dout[7:0];
            r_state <= LOAD;
          end else if (w_go_cred) begin
            r_state <= CRED;
          end else if (w_go_idle) begin
            r_state <= LOAD_IDLE;
          end
        end
        CRED: begin
          if (w_cred_ok) begin
            r_state   <= SEND;
            r_tx_req  <= 1'b1;
            r_tx_st   <= 1'b1;
            r_tx_end  <= 1'b0;
            r_tx_data <= w_next_word;
            r_idx     <= '0;
          end
        end
        SEND: begin
          if (tx.tx_rdy) begin
            r_tx_req <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_tx_st   <= 1'b0;
              r_tx_end  <= 1'b0;
              r_tx_data <= '0;
              r_idx     <= '0;
              r_tag     <= r_tag + 8'd1;
              r_sent    <= r_sent + 16'd1;
              r_state   <= LOAD_IDLE;
            end else begin
              r_idx     <= w_load_idx;
              r_tx_data <= w_next_word;
              r_tx_st   <= 1'b0;
              r_tx_end  <= (w_load_idx == LAST_IDX);
            end
          end
        end
        default: r_state <= LOAD_IDLE;
      endcase
    end
  end

  assign tx.tx_req    = r_tx_req;
  assign tx.tx_st     = r_tx_st;
  assign tx.tx_end    = r_tx_end;
  assign tx.tx_data   = r_tx_data;
  assign tlp_sent_cnt = r_sent;
  assign drop_cnt     = r_drop;

endmodule
